// File: rtl/btb_assoc_pkg.sv
// btb_assoc_pkg: shared types for the branch target buffer
package btb_assoc_pkg;
    typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} btb_ctr_t;
    localparam btb_ctr_t BTB_CTR_INIT = WT;
    typedef enum logic {IDLE, CLEAR} btb_state_t;
endpackage

// File: rtl/plru_tree.sv
// plru_tree: tree pseudo-LRU victim select and next bits after touching a way
module plru_tree #(
    parameter int WAYS = 4,
    localparam int LW = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] bits,
    input  logic [LW-1:0]   touch_way,
    output logic [LW-1:0]   victim,
    output logic [WAYS-2:0] next_bits
);
    // Heap layout: node n has children 2n+1 (left) and 2n+2 (right).
    always_comb begin : walk
        int vn;
        int tn;
        logic b;
        logic t;
        victim = '0;
        next_bits = bits;
        vn = 0;
        tn = 0;
        b = 1'b0;
        t = 1'b0;
        for (int l = 0; l < LW; l++) begin
            b = 1'(bits >> vn);
            victim[LW-1-l] = b;
            vn = 2 * vn + 1 + int'(b);
            t = touch_way[LW-1-l];
            for (int j = 0; j < WAYS - 1; j++)
                if (j == tn) next_bits[j] = ~t;
            tn = 2 * tn + 1 + int'(t);
        end
    end
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with 2-bit counters,
// tree pseudo-LRU replacement and a set-by-set invalidation sweep
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    output logic        busy,
    input  logic [15:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [15:0] pred_target,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 15 - IDX_W;
    localparam int LW = $clog2(WAYS);

    btb_state_t state, state_d;
    logic [IDX_W-1:0] sweep_idx, sweep_idx_d;
    logic [WAYS-1:0]  valid  [SETS];
    logic [TAG_W-1:0] tag    [SETS][WAYS];
    logic [15:0]      target [SETS][WAYS];
    btb_ctr_t         ctr    [SETS][WAYS];
    logic [WAYS-2:0]  plru   [SETS];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit, u_inv;
    logic [LW-1:0]    l_way, u_way, inv_way, victim, sel_way;
    logic [WAYS-2:0]  next_bits;
    btb_ctr_t         u_ctr, ctr_nx;

    assign l_idx = IDX_W'(lookup_pc >> 1);
    assign l_tag = TAG_W'(lookup_pc >> (IDX_W + 1));
    assign u_idx = IDX_W'(upd_pc >> 1);
    assign u_tag = TAG_W'(upd_pc >> (IDX_W + 1));

    // Descending scans so the lowest matching / invalid way wins.
    always_comb begin
        l_hit = 1'b0;
        l_way = '0;
        u_hit = 1'b0;
        u_way = '0;
        u_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[l_idx][w] && tag[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_way = LW'(w);
            end
            if (valid[u_idx][w] && tag[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = LW'(w);
            end
            if (!valid[u_idx][w]) begin
                u_inv = 1'b1;
                inv_way = LW'(w);
            end
        end
    end

    assign busy = state == CLEAR;
    assign pred_hit = l_hit && !busy;
    assign pred_taken = pred_hit && ctr[l_idx][l_way][1];
    assign pred_target = pred_taken ? target[l_idx][l_way] : lookup_pc + 16'd2;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits(plru[u_idx]),
        .touch_way(sel_way),
        .victim(victim),
        .next_bits(next_bits)
    );

    assign sel_way = u_hit ? u_way : (u_inv ? inv_way : victim);
    assign u_ctr = ctr[u_idx][u_way];
    assign ctr_nx = !u_hit ? BTB_CTR_INIT :
                    upd_taken ? (u_ctr == ST ? ST : btb_ctr_t'(u_ctr + 2'd1)) :
                    (u_ctr == SNT ? SNT : btb_ctr_t'(u_ctr - 2'd1));

    always_comb begin
        state_d = (flush || (busy && sweep_idx != IDX_W'(SETS - 1))) ? CLEAR : IDLE;
        sweep_idx_d = flush ? '0 : sweep_idx + IDX_W'(busy);
    end

    always_ff @(posedge clk) begin
        state <= rst ? CLEAR : state_d;
        sweep_idx <= rst ? '0 : sweep_idx_d;
    end

    // Updates arriving during a sweep are dropped; the sweep alone owns the arrays.
    always_ff @(posedge clk) begin
        if (busy) begin
            valid[sweep_idx] <= '0;
            plru[sweep_idx] <= '0;
        end else if (upd_valid && (u_hit || upd_taken)) begin
            plru[u_idx] <= next_bits;
            valid[u_idx][sel_way] <= 1'b1;
            tag[u_idx][sel_way] <= u_tag;
            ctr[u_idx][sel_way] <= ctr_nx;
            if (upd_taken) target[u_idx][sel_way] <= upd_target;
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed and random checks of btb_assoc against an entry-level reference model
module tb_btb_assoc;
    localparam int WAYS = 4;
    localparam int SETS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] lookup_pc = 16'h0;
    logic        pred_hit, pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = 16'h0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = 16'h0;

    always #5 clk = ~clk;

    btb_assoc #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy),
        .lookup_pc(lookup_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target)
    );

    // Entries are keyed by the branch's halfword address; the set is that address mod SETS.
    bit          m_v    [SETS][WAYS];
    int          m_line [SETS][WAYS];
    logic [15:0] m_tgt  [SETS][WAYS];
    int          m_ctr  [SETS][WAYS];
    bit          m_plru [SETS][WAYS-1];
    int          m_busy = 0;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        o_busy, o_hit, o_taken;
    logic [15:0] o_tgt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic int m_victim(input int s);
        int lo = 0, size = WAYS, n = 0;
        while (size > 1) begin
            size /= 2;
            if (m_plru[s][n]) begin lo += size; n = 2 * n + 2; end
            else n = 2 * n + 1;
        end
        return lo;
    endfunction

    task automatic m_touch(input int s, input int w);
        int lo = 0, size = WAYS, n = 0;
        while (size > 1) begin
            size /= 2;
            if (w >= lo + size) begin m_plru[s][n] = 1'b0; lo += size; n = 2 * n + 2; end
            else begin m_plru[s][n] = 1'b1; n = 2 * n + 1; end
        end
    endtask

    task automatic model_step();
        int line, s, hw, w;
        if (m_busy == 0 && upd_valid) begin
            line = int'(upd_pc >> 1);
            s = line % SETS;
            hw = -1;
            for (int i = 0; i < WAYS; i++) if (hw < 0 && m_v[s][i] && m_line[s][i] == line) hw = i;
            if (hw >= 0) begin
                if (upd_taken) begin
                    m_ctr[s][hw] = m_ctr[s][hw] < 3 ? m_ctr[s][hw] + 1 : 3;
                    m_tgt[s][hw] = upd_target;
                end else m_ctr[s][hw] = m_ctr[s][hw] > 0 ? m_ctr[s][hw] - 1 : 0;
                m_touch(s, hw);
            end else if (upd_taken) begin
                w = -1;
                for (int i = 0; i < WAYS; i++) if (w < 0 && !m_v[s][i]) w = i;
                if (w < 0) w = m_victim(s);
                m_v[s][w] = 1'b1;
                m_line[s][w] = line;
                m_tgt[s][w] = upd_target;
                m_ctr[s][w] = 2;
                m_touch(s, w);
            end
        end
        if (rst || flush) begin
            for (int i = 0; i < SETS; i++) begin
                for (int j = 0; j < WAYS; j++) m_v[i][j] = 1'b0;
                for (int j = 0; j < WAYS - 1; j++) m_plru[i][j] = 1'b0;
            end
            m_busy = SETS;
            if (rst) chk_en = 1'b1;
        end else if (m_busy > 0) m_busy--;
    endtask

    task automatic cycle();
        int line, s, ew;
        bit e_hit, e_taken;
        logic [15:0] e_tgt;
        @(negedge clk);
        o_busy = busy;
        o_hit = pred_hit;
        o_taken = pred_taken;
        o_tgt = pred_target;
        if (chk_en) begin
            line = int'(lookup_pc >> 1);
            s = line % SETS;
            e_hit = 1'b0;
            ew = 0;
            if (m_busy == 0)
                for (int i = 0; i < WAYS; i++)
                    if (!e_hit && m_v[s][i] && m_line[s][i] == line) begin e_hit = 1'b1; ew = i; end
            e_taken = e_hit && m_ctr[s][ew] >= 2;
            e_tgt = e_taken ? m_tgt[s][ew] : lookup_pc + 16'd2;
            check("busy", 32'(o_busy), 32'(m_busy > 0));
            check("hit", 32'(o_hit), 32'(e_hit));
            check("taken", 32'(o_taken), 32'(e_taken));
            check("target", 32'(o_tgt), 32'(e_tgt));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [15:0] lpc, input bit uv, input logic [15:0] upc,
                         input bit ut, input logic [15:0] utgt);
        lookup_pc = lpc;
        upd_valid = uv;
        upd_pc = upc;
        upd_taken = ut;
        upd_target = utgt;
        cycle();
    endtask

    task automatic look(input logic [15:0] pc);
        drive(pc, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic upd(input logic [15:0] pc, input bit t, input logic [15:0] tgt);
        drive(pc, 1'b1, pc, t, tgt);
    endtask

    task automatic busy_len(input logic [15:0] pc, output int n);
        n = 0;
        do begin
            look(pc);
            if (o_busy) n++;
        end while (o_busy && n < 200);
    endtask

    task automatic do_flush();
        int n;
        flush = 1'b1;
        look(16'h0);
        flush = 1'b0;
        busy_len(16'h0, n);
    endtask

    initial begin
        int n;
        logic [15:0] pc;
        cycle();
        rst = 1'b0;
        look(16'h3000);
        check("rst_busy", 32'(o_busy), 32'd1);
        check("rst_hit", 32'(o_hit), 32'd0);
        check("rst_tgt", 32'(o_tgt), 32'h3002);
        busy_len(16'h3000, n);
        check("rst_busy_len", 32'(n + 1), 32'd64);

        upd(16'h3000, 1'b1, 16'h3040);
        look(16'h3000);
        check("alloc_hit", 32'(o_hit), 32'd1);
        check("alloc_taken", 32'(o_taken), 32'd1);
        check("alloc_tgt", 32'(o_tgt), 32'h3040);
        look(16'h3002);
        check("nb_hit", 32'(o_hit), 32'd0);
        check("nb_tgt", 32'(o_tgt), 32'h3004);

        upd(16'h3000, 1'b0, 16'h0);
        look(16'h3000);
        check("ctr1_hit", 32'(o_hit), 32'd1);
        check("ctr1_taken", 32'(o_taken), 32'd0);
        check("ctr1_tgt", 32'(o_tgt), 32'h3002);
        upd(16'h3000, 1'b0, 16'h0);
        upd(16'h3000, 1'b0, 16'h0);
        upd(16'h3000, 1'b1, 16'h3040);
        look(16'h3000);
        check("ctr_sat_taken", 32'(o_taken), 32'd0);
        upd(16'h3000, 1'b1, 16'h3040);
        look(16'h3000);
        check("ctr2_taken", 32'(o_taken), 32'd1);
        check("ctr2_tgt", 32'(o_tgt), 32'h3040);

        upd(16'h2000, 1'b0, 16'h2222);
        look(16'h2000);
        check("nt_miss_hit", 32'(o_hit), 32'd0);
        flush = 1'b1;
        look(16'h2000);
        flush = 1'b0;
        upd(16'h2000, 1'b1, 16'h2222);
        busy_len(16'h2000, n);
        look(16'h2000);
        check("busy_upd_hit", 32'(o_hit), 32'd0);

        do_flush();
        upd(16'h1000, 1'b1, 16'h0a00);
        upd(16'h1080, 1'b1, 16'h0a80);
        upd(16'h1100, 1'b1, 16'h0b00);
        upd(16'h1180, 1'b1, 16'h0b80);
        upd(16'h1200, 1'b1, 16'h0c00);
        look(16'h1000);
        check("evict_1000", 32'(o_hit), 32'd0);
        look(16'h1080);
        check("keep_1080", 32'(o_hit), 32'd1);
        look(16'h1100);
        check("keep_1100", 32'(o_hit), 32'd1);
        look(16'h1180);
        check("keep_1180", 32'(o_hit), 32'd1);
        look(16'h1200);
        check("new_1200", 32'(o_hit), 32'd1);
        check("new_1200_tgt", 32'(o_tgt), 32'h0c00);

        upd(16'h4000, 1'b1, 16'h4444);
        check("same_cyc_hit", 32'(o_hit), 32'd0);
        look(16'h4000);
        check("next_cyc_hit", 32'(o_hit), 32'd1);
        flush = 1'b1;
        look(16'h0);
        flush = 1'b0;
        repeat (20) look(16'h0);
        flush = 1'b1;
        look(16'h0);
        flush = 1'b0;
        busy_len(16'h0, n);
        check("reflush_busy_len", 32'(n), 32'd64);

        repeat (4000) begin
            pc = 16'((($urandom_range(0, 7)) << 7) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
            lookup_pc = pc;
            pc = 16'((($urandom_range(0, 7)) << 7) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
            upd_pc = pc;
            upd_valid = $urandom_range(0, 1) == 1;
            upd_taken = $urandom_range(0, 9) < 6;
            upd_target = 16'($urandom);
            flush = $urandom_range(0, 299) == 0;
            rst = $urandom_range(0, 999) == 0;
            cycle();
        end
        rst = 1'b0;
        flush = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised set-associative branch target buffer for the lc3b pipeline.
- Fetch/ID presents a PC and gets a hit flag, a direction prediction and a next-PC target in the same cycle.
- Writeback trains the buffer with resolved branch outcome and target.
- Adds what the previous BTB lacked: configurable sets/ways, 2-bit direction counters, tree pseudo-LRU, a synchronous reset/flush invalidation sweep, and a correct 16-bit tag/index split.

Parameters:
WAYS, 4, associativity; power of 2, at least 2.
SETS, 64, number of sets; power of 2, at least 2; IDX_W = log2(SETS).
TAG_W, 15-IDX_W, derived tag width (localparam, not overridable).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  one-cycle pulse starts an invalidation sweep.
busy  out  1  high while a sweep is in progress.
lookup_pc  in  16  PC being predicted (lc3b_word).
pred_hit  out  1  valid tag match for lookup_pc.
pred_taken  out  1  pred_hit AND counter[1].
pred_target  out  16  stored target if pred_taken, else lookup_pc+2.
upd_valid  in  1  writeback branch resolved this cycle.
upd_pc  in  16  PC of the resolved branch.
upd_taken  in  1  resolved direction.
upd_target  in  16  resolved taken target.

Behaviour:
- Address split: index = pc[IDX_W:1]; tag = pc[15:IDX_W+1]. pc[0] is ignored.
- Per way per set: valid, tag[TAG_W], target[16], ctr[2]. Per set: WAYS-1 PLRU bits.
- Lookup is combinational from registered arrays.
  - Multiple matching ways cannot be created; if they exist anyway, the lowest way wins.
  - Lookup does not touch PLRU.
- While busy=1: pred_hit=0, pred_taken=0, pred_target=lookup_pc+2.
- FSM has two states, IDLE and CLEAR.
  - rst=1: state←CLEAR, sweep_idx←0, busy=1. Array contents are irrelevant until cleared.
  - CLEAR: each cycle clear valid of all ways and the PLRU bits of set sweep_idx, then increment sweep_idx. At sweep_idx==SETS-1, go to IDLE.
  - busy is high for exactly SETS cycles after the last rst/flush edge.
  - flush or rst during CLEAR restarts the sweep at index 0. rst takes priority over everything.
  - IDLE + flush → CLEAR, sweep_idx←0.
- Update (IDLE only; upd_valid while busy is dropped silently):
  - Hit, taken: ctr saturating +1 (max 3), target←upd_target, touch PLRU for that way.
  - Hit, not taken: ctr saturating -1 (min 0), target unchanged, touch PLRU for that way.
  - Miss, taken: allocate. Victim is the lowest-index invalid way, else the PLRU victim. Write valid=1, tag, target, ctr=2'b10. Touch PLRU.
  - Miss, not taken: no state change.
- Tree PLRU:
  - Node bit 0 points left. Victim walks the bits from the root.
  - Touch sets each node on the path to point away from the touched way.
- Same-cycle lookup and update to the same set: lookup sees pre-update contents. There is no bypass.
- Reset values of outputs: busy=1, pred_hit=0, pred_taken=0, pred_target=lookup_pc+2.

Decomposition:
- lc3b_types gains btb_ctr_t, a 2-bit enum: SNT=0, WNT=1, WT=2, ST=3.
- lc3b_types also gains BTB_CTR_INIT=WT and a btb_state_t enum {IDLE, CLEAR}.
- Sub-module plru_tree #(WAYS): combinational victim select and next-bits on touch. Instantiated once for the lookup/victim path of the update set.

Test Plan:
1. Reset sweep: assert rst 1 cycle → busy stays high exactly 64 cycles. During that window, lookup 0x3000 → hit=0, target=0x3002.
2. Allocate and hit: update pc=0x3000, taken, target=0x3040 → next cycle lookup 0x3000 gives hit=1, taken=1, target=0x3040. Lookup 0x3002 gives hit=0, target=0x3004.
3. Counter: from test 2, one not-taken update → hit=1, taken=0, target=0x3002. Two more not-taken → ctr=0. Then two taken → taken=1 (ctr=2).
4. Not-taken miss: update pc=0x2000, not taken → lookup 0x2000 hit=0. Update during busy (after flush) → ignored, lookup hit=0 once idle.
5. PLRU eviction: allocate taken 0x1000, 0x1080, 0x1100, 0x1180 (same set), then 0x1200 → 0x1000 misses; the other four hit.
6. Same-cycle conflict: update 0x4000 taken while looking up 0x4000 → hit=0 that cycle, hit=1 next cycle. Flush mid-sweep → busy extends to 64 cycles from the flush.
